// File: rtl/fifo_rr_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rr_wr_arbiter
//  Description : Round-robin arbiter sharing a single FIFO write port among
//                NUM_REQ producers with valid/ready handshakes. A granted
//                producer may write bursts of up to MAX_BURST beats.
//  Ports       : clk, rst_n (sync, active-low)
//                req_valid/req_data/req_ready  - producer side
//                fifo_full/fifo_w_en/fifo_data - FIFO write side
//                grant_id, busy                - registered grant status
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_rr_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_w_en,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic                          busy
);

    localparam int c_BCW = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ID_WIDTH-1:0] r_grant_id;
    logic [ID_WIDTH-1:0] w_grant_next;
    logic [ID_WIDTH-1:0] r_last_grant;
    logic [ID_WIDTH-1:0] w_last_next;
    logic [c_BCW-1:0]    r_beat_cnt;
    logic [c_BCW-1:0]    w_beat_next;

    logic [ID_WIDTH-1:0] w_base;
    logic [ID_WIDTH-1:0] w_pick;
    logic                w_found;
    logic                w_owner_valid;
    logic                w_xfer;
    logic                w_last_beat;
    logic                w_release;

    // Scan origin: in IDLE resume after the last released owner; in GRANT
    // scan after the current owner so a re-pick of the same owner only
    // happens when nobody else is asking.
    assign w_base = (r_state == ST_GRANT) ? r_grant_id : r_last_grant;

    // Iterate from the farthest offset down so the nearest valid index wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_valid[ID_WIDTH'((int'(w_base) + k) % NUM_REQ)]) begin
                w_found = 1'b1;
                w_pick  = ID_WIDTH'((int'(w_base) + k) % NUM_REQ);
            end
        end
    end

    assign w_owner_valid = req_valid[r_grant_id];
    assign w_xfer        = rst_n && (r_state == ST_GRANT) && w_owner_valid && !fifo_full;
    assign w_last_beat   = (({1'b0, r_beat_cnt} + (c_BCW+1)'(1)) == (c_BCW+1)'(MAX_BURST));
    // Release on the final beat of a burst, or as soon as the owner goes idle
    // (an idle owner releases even while the FIFO is full).
    assign w_release     = (r_state == ST_GRANT) && ((w_xfer && w_last_beat) || !w_owner_valid);

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant_id;
        w_last_next  = r_last_grant;
        w_beat_next  = r_beat_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_next = ST_GRANT;
                    w_grant_next = w_pick;
                    w_beat_next  = '0;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    w_last_next = r_grant_id;
                    w_beat_next = '0;
                    if (w_found) begin
                        w_grant_next = w_pick;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else if (w_xfer) begin
                    w_beat_next = r_beat_cnt + c_BCW'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_grant_id   <= '0;
            r_beat_cnt   <= '0;
            r_last_grant <= ID_WIDTH'(NUM_REQ - 1);
        end else begin
            r_state      <= w_state_next;
            r_grant_id   <= w_grant_next;
            r_beat_cnt   <= w_beat_next;
            r_last_grant <= w_last_next;
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && (r_state == ST_GRANT) && !fifo_full) begin
            req_ready[r_grant_id] = 1'b1;
        end
    end

    assign fifo_w_en = w_xfer;
    assign fifo_data = req_data[int'(r_grant_id)*DATA_WIDTH +: DATA_WIDTH];
    assign grant_id  = r_grant_id;
    assign busy      = (r_state == ST_GRANT);

endmodule
`default_nettype wire

// File: tb/tb_fifo_rr_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_rr_wr_arbiter
//  Description : Directed self-checking bench for fifo_rr_wr_arbiter. Two
//                instances share inputs: MAX_BURST=4 and MAX_BURST=1.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_rr_wr_arbiter;

    localparam int c_NR  = 4;
    localparam int c_DW  = 8;
    localparam int c_IDW = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [c_NR-1:0]      req_valid;
    logic [c_NR*c_DW-1:0] req_data;
    logic                 fifo_full;

    logic [c_NR-1:0]  rdy4, rdy1;
    logic             wen4, wen1;
    logic [c_DW-1:0]  dat4, dat1;
    logic [c_IDW-1:0] gid4, gid1;
    logic             busy4, busy1;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fifo_rr_wr_arbiter #(.NUM_REQ(c_NR), .DATA_WIDTH(c_DW), .MAX_BURST(4)) u_mb4 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rdy4), .fifo_full(fifo_full), .fifo_w_en(wen4),
        .fifo_data(dat4), .grant_id(gid4), .busy(busy4)
    );

    fifo_rr_wr_arbiter #(.NUM_REQ(c_NR), .DATA_WIDTH(c_DW), .MAX_BURST(1)) u_mb1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rdy1), .fifo_full(fifo_full), .fifo_w_en(wen1),
        .fifo_data(dat1), .grant_id(gid1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slice(input int idx, input logic [c_DW-1:0] v);
        req_data[idx*c_DW +: c_DW] = v;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        fifo_full = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    logic [c_DW-1:0] word;

    initial begin
        // ---------------- reset with all requesters valid ----------------
        rst_n     = 1'b0;
        req_valid = 4'hF;
        fifo_full = 1'b0;
        req_data  = 32'hA3A2A1A0;
        #1;
        chk("rst_wen4",  wen4, 0);
        chk("rst_rdy4",  rdy4, 0);
        chk("rst_wen1",  wen1, 0);
        chk("rst_rdy1",  rdy1, 0);
        tick();
        tick();
        chk("rst_busy",  busy4, 0);
        chk("rst_gid",   gid4, 0);
        chk("rst_wen_held", wen4, 0);
        rst_n = 1'b1;
        #1;
        chk("idle_wen4", wen4, 0);
        chk("idle_wen1", wen1, 0);
        chk("idle_rdy4", rdy4, 0);
        tick();
        chk("first_gid4",  gid4, 0);
        chk("first_busy4", busy4, 1);

        // ---------------- MAX_BURST=1 strict round robin -----------------
        for (int i = 0; i < 8; i++) begin
            chk("rr_gid",  gid1, i % 4);
            chk("rr_wen",  wen1, 1);
            chk("rr_data", dat1, 8'hA0 + (i % 4));
            chk("rr_rdy",  rdy1, 4'b0001 << (i % 4));
            tick();
        end

        // ---------------- single requester stream ------------------------
        do_reset();
        req_valid = 4'b0100;
        set_slice(2, 8'h10);
        #1;
        chk("t2_idle_wen", wen4, 0);
        tick();
        word = 8'h10;
        for (int i = 0; i < 10; i++) begin
            set_slice(2, word);
            #1;
            chk("t2_wen",  wen4, 1);
            chk("t2_data", dat4, word);
            chk("t2_gid",  gid4, 2);
            chk("t2_rdy",  rdy4, 4'b0100);
            tick();
            word = word + 8'h01;
        end
        req_valid = '0;
        #1;
        chk("t2_drop_wen",  wen4, 0);
        chk("t2_drop_busy", busy4, 1);
        tick();
        chk("t2_idle_busy", busy4, 0);

        // ---------------- full stall mid-burst ---------------------------
        do_reset();
        req_valid = 4'b0110;
        set_slice(1, 8'h40);
        set_slice(2, 8'h50);
        tick();
        chk("t4_gid0", gid4, 1);
        chk("t4_wen_b0", wen4, 1);
        chk("t4_dat_b0", dat4, 8'h40);
        chk("t4_rdy_b0", rdy4, 4'b0010);
        tick();
        set_slice(1, 8'h41);
        #1;
        chk("t4_wen_b1", wen4, 1);
        chk("t4_dat_b1", dat4, 8'h41);
        tick();
        set_slice(1, 8'h42);
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t4_stall_wen", wen4, 0);
            chk("t4_stall_rdy", rdy4, 0);
            chk("t4_stall_gid", gid4, 1);
            chk("t4_stall_busy", busy4, 1);
            tick();
        end
        fifo_full = 1'b0;
        #1;
        chk("t4_wen_b2", wen4, 1);
        chk("t4_dat_b2", dat4, 8'h42);
        tick();
        set_slice(1, 8'h43);
        #1;
        chk("t4_wen_b3", wen4, 1);
        chk("t4_dat_b3", dat4, 8'h43);
        chk("t4_gid_b3", gid4, 1);
        tick();
        set_slice(1, 8'h44);
        #1;
        chk("t4_handover_gid", gid4, 2);
        chk("t4_handover_dat", dat4, 8'h50);
        chk("t4_handover_rdy", rdy4, 4'b0100);

        // ---------------- early release with same-cycle handover ---------
        do_reset();
        req_valid = 4'b1000;
        set_slice(3, 8'h30);
        set_slice(0, 8'h0A);
        tick();
        req_valid = 4'b1001;
        #1;
        chk("t5_gid3",  gid4, 3);
        chk("t5_wen_b0", wen4, 1);
        chk("t5_dat_b0", dat4, 8'h30);
        tick();
        set_slice(3, 8'h31);
        #1;
        chk("t5_wen_b1", wen4, 1);
        chk("t5_dat_b1", dat4, 8'h31);
        tick();
        req_valid = 4'b0001;
        #1;
        chk("t5_drop_wen", wen4, 0);
        tick();
        chk("t5_new_gid",  gid4, 0);
        chk("t5_new_busy", busy4, 1);
        chk("t5_new_wen",  wen4, 1);
        chk("t5_new_dat",  dat4, 8'h0A);
        chk("t5_last_grant", u_mb4.r_last_grant, 3);

        // ---------------- reset during a burst ---------------------------
        do_reset();
        req_valid = 4'b0010;
        set_slice(1, 8'h60);
        tick();
        chk("t6_wen_b0", wen4, 1);
        tick();
        set_slice(1, 8'h61);
        #1;
        chk("t6_wen_b1", wen4, 1);
        tick();
        set_slice(1, 8'h62);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_wen", wen4, 0);
        chk("t6_rst_rdy", rdy4, 0);
        tick();
        chk("t6_rst_busy", busy4, 0);
        chk("t6_rst_gid",  gid4, 0);
        rst_n     = 1'b1;
        req_valid = 4'b0011;
        set_slice(0, 8'h70);
        #1;
        chk("t6_idle_wen", wen4, 0);
        tick();
        chk("t6_regrant_gid", gid4, 0);
        chk("t6_regrant_dat", dat4, 8'h70);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
